// File: rtl/cache_types.sv
// Shared types and default sizes for the cache memory-side blocks.
package cache_types;

  localparam int DEF_LINE_BITS   = 256;
  localparam int DEF_OFFSET_BITS = 5;
  localparam int ADDR_BITS       = 32;

  typedef logic [DEF_LINE_BITS-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READ_MEM = 2'd1,
    DRAIN    = 2'd2,
    RESP     = 2'd3
  } wb_state_e;

endpackage

// File: rtl/writeback_buffer_entry.sv
// Single victim-line slot: valid flag, line tag and line data, plus a tag
// compare against the current cache request.
module wb_entry import cache_types::*; #(
  parameter int LINE_BITS   = DEF_LINE_BITS,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_load,
  input  logic                             i_clear,
  input  logic [ADDR_BITS-1:OFFSET_BITS]   i_load_tag,
  input  logic [LINE_BITS-1:0]             i_load_data,
  input  logic [ADDR_BITS-1:OFFSET_BITS]   i_cmp_tag,
  output logic                             o_valid,
  output logic                             o_match,
  output logic [ADDR_BITS-1:0]             o_addr,
  output logic [LINE_BITS-1:0]             o_data
);

  logic                           r_valid;
  logic [ADDR_BITS-1:OFFSET_BITS] r_tag;
  logic [LINE_BITS-1:0]           r_data;

  // Valid flag: set on capture, cleared when the drain completes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  // Line tag and data: captured on load, overwritten in place on coalesce.
  always_ff @(posedge clk) begin
    // NOTE: the payload is deliberately not reset; r_valid alone says whether
    // it means anything, and leaving 256+ data flops off the reset net is free.
    if (i_load) begin
      r_tag  <= i_load_tag;
      r_data <= i_load_data;
    end
  end

  assign o_valid = r_valid;
  assign o_match = r_valid && (r_tag == i_cmp_tag);
  assign o_addr  = {r_tag, {OFFSET_BITS{1'b0}}};
  assign o_data  = r_data;

endmodule

// File: rtl/writeback_buffer.sv
// Posted single-entry write-back buffer between the cache line port and the
// cacheline adaptor. Evictions are acked at once, read misses go out first,
// and the parked line drains whenever the cache is quiet.
module writeback_buffer import cache_types::*; #(
  parameter int LINE_BITS   = DEF_LINE_BITS,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          mem_address,
  input  logic [LINE_BITS-1:0] mem_wdata,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic [LINE_BITS-1:0] mem_rdata,
  output logic                 mem_resp,
  output logic [31:0]          pmem_address,
  output logic [LINE_BITS-1:0] pmem_wdata,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
);

  wb_state_e                      r_state;
  wb_state_e                      w_next_state;
  logic [LINE_BITS-1:0]           r_rdata;

  logic [31:OFFSET_BITS]          w_req_tag;
  logic                           w_unused;
  logic                           w_load;
  logic                           w_clear;
  logic                           w_rd_from_buf;
  logic                           w_rd_from_mem;
  logic                           w_buf_valid;
  logic                           w_match;
  logic [31:0]                    w_buf_addr;
  logic [LINE_BITS-1:0]           w_buf_data;

  // Byte offset only selects within a line; the buffer works on whole lines.
  assign w_req_tag = mem_address[31:OFFSET_BITS];
  assign w_unused  = &{1'b0, mem_address[OFFSET_BITS-1:0]};

  wb_entry #(
    .LINE_BITS   (LINE_BITS),
    .OFFSET_BITS (OFFSET_BITS)
  ) u_entry (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_clear     (w_clear),
    .i_load_tag  (w_req_tag),
    .i_load_data (mem_wdata),
    .i_cmp_tag   (w_req_tag),
    .o_valid     (w_buf_valid),
    .o_match     (w_match),
    .o_addr      (w_buf_addr),
    .o_data      (w_buf_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and buffer control; reads take priority over writes in IDLE.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and infers a latch.
    w_next_state  = r_state;
    w_load        = 1'b0;
    w_clear       = 1'b0;
    w_rd_from_buf = 1'b0;
    w_rd_from_mem = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (mem_read) begin
          if (w_match) begin
            w_rd_from_buf = 1'b1;
            w_next_state  = RESP;
          end else begin
            w_next_state  = READ_MEM;
          end
        end else if (mem_write) begin
          if (!w_buf_valid || w_match) begin
            w_load       = 1'b1;
            w_next_state = RESP;
          end else begin
            w_next_state = DRAIN;
          end
        end else if (w_buf_valid) begin
          w_next_state = DRAIN;
        end
      end
      READ_MEM: begin
        if (pmem_resp) begin
          w_rd_from_mem = 1'b1;
          w_next_state  = RESP;
        end
      end
      DRAIN: begin
        if (pmem_resp) begin
          w_clear      = 1'b1;
          w_next_state = IDLE;
        end
      end
      RESP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Moore-decoded handshake outputs toward the cache and the adaptor.
  always_comb begin
    mem_resp     = (r_state == RESP);
    pmem_read    = (r_state == READ_MEM);
    pmem_write   = (r_state == DRAIN);
    pmem_address = (r_state == DRAIN) ? w_buf_addr
                                      : {w_req_tag, {OFFSET_BITS{1'b0}}};
  end

  // Read-return register, loaded from the buffer on a hit or from memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_rd_from_buf) begin
      r_rdata <= w_buf_data;
    end else if (w_rd_from_mem) begin
      r_rdata <= pmem_rdata;
    end
  end

  assign mem_rdata  = r_rdata;
  assign pmem_wdata = w_buf_data;

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: the bench plays both the cache and the
// adaptor, stepping one clock at a time and checking handshakes against
// hand-computed expectations.
module tb_writeback_buffer;
  import cache_types::*;

  logic        clk;
  logic        rst;
  logic [31:0] mem_address;
  line_t       mem_wdata;
  logic        mem_read;
  logic        mem_write;
  line_t       mem_rdata;
  logic        mem_resp;
  logic [31:0] pmem_address;
  line_t       pmem_wdata;
  logic        pmem_read;
  logic        pmem_write;
  line_t       pmem_rdata;
  logic        pmem_resp;

  int n_assert = 0;
  int n_fail   = 0;

  line_t line_a, line_b, line_c, line_r;

  writeback_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cache write from IDLE with a free or matching slot: acked on the next edge.
  task automatic write_acked(input logic [31:0] a, input line_t d, input string tag);
    mem_address = a;
    mem_wdata   = d;
    mem_write   = 1'b1;
    tick();
    check({tag, "_resp"}, mem_resp, 1'b1);
    check({tag, "_no_pmem"}, {pmem_read, pmem_write}, 2'b00);
    mem_write   = 1'b0;
  endtask

  // Wait (bounded) for a drain, check it, then complete it from the adaptor side.
  task automatic drain_expect(input logic [31:0] a, input line_t d, input string tag);
    for (int i = 0; i < 8 && !pmem_write; i++) tick();
    check({tag, "_pmem_write"}, pmem_write, 1'b1);
    check({tag, "_addr"}, pmem_address, a);
    check({tag, "_wdata"}, pmem_wdata, d);
    check({tag, "_no_read"}, pmem_read, 1'b0);
    tick();
    check({tag, "_hold"}, {pmem_write, pmem_address}, {1'b1, a});
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    check({tag, "_done"}, pmem_write, 1'b0);
  endtask

  initial begin
    line_a = {8{32'hAAAA_0001}};
    line_b = {8{32'hBBBB_0002}};
    line_c = {8{32'hCCCC_0003}};
    line_r = {4{64'h1234_5678_9ABC_DEF0}};
    rst         = 1'b1;
    mem_address = '0;
    mem_wdata   = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    pmem_rdata  = '0;
    pmem_resp   = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_outputs", {mem_resp, pmem_read, pmem_write}, 3'b000);
    check("rst_rdata", mem_rdata, '0);
    rst = 1'b0;
    tick();

    // Eviction into an empty buffer, then opportunistic drain.
    write_acked(32'h0000_1040, line_a, "wr_empty");
    drain_expect(32'h0000_1040, line_a, "idle_drain");
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 6; i++) begin tick(); seen |= pmem_write; end
      check("drained_empty", seen, 1'b0);
    end

    // Read hit on the buffered line, served locally.
    write_acked(32'h0000_1040, line_a, "wr_hit");
    mem_address = 32'h0000_1058;
    mem_read    = 1'b1;
    tick();
    check("hit_idle_gap", mem_resp, 1'b0);
    tick();
    check("hit_resp", mem_resp, 1'b1);
    check("hit_rdata", mem_rdata, line_a);
    check("hit_no_pmem_read", pmem_read, 1'b0);
    mem_read = 1'b0;
    drain_expect(32'h0000_1040, line_a, "hit_drain");

    // Reset with a line parked: it is discarded, never drained.
    write_acked(32'h0000_1040, line_a, "wr_pre_rst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_rdata_clear", mem_rdata, '0);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 6; i++) begin tick(); seen |= pmem_write; end
      check("rst_discard", seen, 1'b0);
    end

    // Reset during READ_MEM drops the adaptor request; address is line-aligned.
    mem_address = 32'h0000_201C;
    mem_read    = 1'b1;
    tick();
    check("rm_read", pmem_read, 1'b1);
    check("rm_align", pmem_address, 32'h0000_2000);
    rst      = 1'b1;
    mem_read = 1'b0;
    tick();
    check("rm_rst_read", pmem_read, 1'b0);
    rst = 1'b0;
    tick();

    // Read miss goes ahead of the pending drain.
    write_acked(32'h0000_1040, line_a, "wr_miss");
    mem_address = 32'h0000_2000;
    mem_read    = 1'b1;
    for (int i = 0; i < 4 && !(pmem_read || pmem_write); i++) tick();
    check("miss_first", {pmem_read, pmem_write}, 2'b10);
    check("miss_addr", pmem_address, 32'h0000_2000);
    pmem_rdata = line_r;
    pmem_resp  = 1'b1;
    tick();
    pmem_resp  = 1'b0;
    check("miss_resp", mem_resp, 1'b1);
    check("miss_rdata", mem_rdata, line_r);
    mem_read = 1'b0;
    drain_expect(32'h0000_1040, line_a, "miss_drain");

    // Conflicting eviction: old line drains before the new one is acked.
    write_acked(32'h0000_1040, line_a, "wr_conf_a");
    mem_address = 32'h0000_3000;
    mem_wdata   = line_b;
    mem_write   = 1'b1;
    tick();
    tick();
    check("conf_drain", pmem_write, 1'b1);
    check("conf_drain_addr", pmem_address, 32'h0000_1040);
    check("conf_drain_data", pmem_wdata, line_a);
    check("conf_wait", mem_resp, 1'b0);
    tick();
    check("conf_wait2", {mem_resp, pmem_write}, 2'b01);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    check("conf_after_drain", {mem_resp, pmem_write}, 2'b00);
    tick();
    check("conf_b_resp", mem_resp, 1'b1);
    mem_write = 1'b0;
    drain_expect(32'h0000_3000, line_b, "conf_b_drain");

    // Same-line eviction coalesces; the later drain carries the newer data.
    write_acked(32'h0000_1040, line_a, "wr_coal_a");
    mem_wdata = line_c;
    mem_write = 1'b1;
    tick();
    tick();
    check("coal_resp", mem_resp, 1'b1);
    check("coal_no_write", pmem_write, 1'b0);
    mem_write = 1'b0;
    drain_expect(32'h0000_1040, line_c, "coal_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
